fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have parameter HANDLER, default 32'h0000_4180, exception entry address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall_D  input  1  hazard stall; PC must not advance.
REQ-006 SHALL have port req_exc  input  1  exception/interrupt request from CP0.
REQ-007 SHALL have ports eret_D  input  1 and epc  input  32, eret in D and its return target.
REQ-008 SHALL have ports jmp_D  input  1 and jmp_target  input  32, j/jal/jr in D and its target.
REQ-009 SHALL have ports br_taken_D  input  1 and br_target  input  32, taken branch in D and its target.
REQ-010 SHALL have port imem_ready  input  1  instruction memory accepts/returns the current fetch.
REQ-011 SHALL have port imem_req  output  1  fetch request for pc_F.
REQ-012 SHALL have port pc_F  output  32  current fetch address.
REQ-013 SHALL have port redir_pend  output  1  a latched redirect is waiting.

Function
REQ-014 SHALL implement states BOOT, FETCH, WAIT; BOOT->FETCH unconditionally after one cycle.
REQ-015 SHALL hold imem_req=0 in BOOT and imem_req=1 in FETCH and WAIT.
REQ-016 SHALL define completion as imem_req && imem_ready; FETCH->WAIT when imem_req && !imem_ready, WAIT->FETCH on completion.
REQ-017 SHALL resolve concurrent redirects by fixed priority req_exc > eret_D > jmp_D > br_taken_D; target HANDLER, epc, jmp_target, br_target respectively.
REQ-018 SHALL, on completion with !stall_D and no redirect or pending entry, set pc_F <= pc_F + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL, on completion with a redirect this cycle, load pc_F with the winning target even if a pending entry exists, and clear the pending entry.
REQ-020 SHALL, on completion with no new redirect and a pending entry, load pc_F with the pending target and clear it.
REQ-021 SHALL, when a redirect occurs without completion or under stall_D, latch it into a one-entry pending register; a new request overwrites only if of equal or higher priority.
REQ-022 SHALL treat req_exc as overriding stall_D: with req_exc and completion, pc_F <= HANDLER regardless of stall_D.
REQ-023 SHALL ignore eret_D, jmp_D, br_taken_D while stall_D=1 except to latch per REQ-021 (stalled D is re-presented; duplicate latch is harmless).
REQ-024 SHALL drive redir_pend high exactly while the pending register is valid; one-cycle latency from the latching edge.
REQ-025 SHALL keep pc_F stable while imem_req=1 and no completion.

Reset
REQ-026 SHALL on reset set state=BOOT, pc_F=RESET_PC, pending cleared, imem_req=0, redir_pend=0.
REQ-027 SHALL let reset override every input including req_exc; reset mid-WAIT abandons the fetch.

Configuration
REQ-028 SHALL, with FETCH_PERF_CNT_EN defined, add outputs redir_cnt (32) counting pc_F loads from redirect/pending and wait_cnt (32) counting cycles in WAIT, both wrapping, cleared by reset.
REQ-029 SHALL, without FETCH_PERF_CNT_EN, omit these ports and counters entirely with otherwise identical behaviour.

Verification
REQ-030 Reset, imem_ready=1 constant -> pc_F 0x3000, 0x3000 (BOOT), 0x3004, 0x3008 on successive edges.
REQ-031 pc_F=0x3010, imem_ready=0 two cycles, br_taken_D=1 target 0x3100 in first -> redir_pend=1, pc_F holds, then pc_F=0x3100 after completion.
REQ-032 Same cycle req_exc=1, jmp_D=1 target 0x3200, stall_D=1, imem_ready=1 -> pc_F=0x4180.
REQ-033 Pending jmp 0x3200, then eret_D=1 epc 0x3050 before completion -> pending overwritten, pc_F=0x3050; reverse order -> eret kept.
REQ-034 pc_F=0xFFFF_FFFC, completion, no redirect -> pc_F=0x0000_0000; with FETCH_PERF_CNT_EN, three redirects -> redir_cnt=3.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing with prioritized redirects and a one-entry pending redirect; FETCH_PERF_CNT_EN adds perf counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] HANDLER  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        req_exc,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic        jmp_D,
  input  logic [31:0] jmp_target,
  input  logic        br_taken_D,
  input  logic [31:0] br_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc_F,
  output logic        redir_pend
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] redir_cnt,
  output logic [31:0] wait_cnt
`endif
);
  typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;
  state_t state;
  logic [31:0] pend_tgt, new_tgt;
  logic [1:0] pend_prio, new_prio;
  logic done, d_redir, any_redir, take_new, take_pend, latch, advance;
  // Stalled D-stage redirects are only latched; the exception alone bypasses the stall.
  always_comb begin
    done      = imem_req & imem_ready;
    d_redir   = eret_D | jmp_D | br_taken_D;
    any_redir = req_exc | d_redir;
    new_prio  = req_exc ? 2'd3 : eret_D ? 2'd2 : jmp_D ? 2'd1 : 2'd0;
    new_tgt   = req_exc ? HANDLER : eret_D ? epc : jmp_D ? jmp_target : br_target;
    take_new  = done & (req_exc | (d_redir & ~stall_D));
    take_pend = done & redir_pend & ~any_redir;
    latch     = any_redir & ~take_new & (~redir_pend | new_prio >= pend_prio);
    advance   = done & ~stall_D & ~any_redir & ~redir_pend;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      imem_req   <= 1'b0;
      pc_F       <= RESET_PC;
      redir_pend <= 1'b0;
      pend_tgt   <= '0;
      pend_prio  <= '0;
    end else begin
      state      <= (state == BOOT || imem_ready) ? FETCH : WAIT;
      imem_req   <= 1'b1;
      pc_F       <= take_new ? new_tgt : take_pend ? pend_tgt : advance ? pc_F + 32'd4 : pc_F;
      redir_pend <= latch | (redir_pend & ~take_new & ~take_pend);
      if (latch) begin
        pend_tgt  <= new_tgt;
        pend_prio <= new_prio;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redir_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      redir_cnt <= redir_cnt + {31'd0, take_new | take_pend};
      wait_cnt  <= wait_cnt + {31'd0, state == WAIT};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
  logic clk = 0, reset, stall_D, req_exc, eret_D, jmp_D, br_taken_D, imem_ready;
  logic [31:0] epc, jmp_target, br_target, pc_F;
  logic imem_req, redir_pend;
  int checks = 0, errors = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redir_cnt, wait_cnt;
`endif
  fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall_D(stall_D), .req_exc(req_exc),
    .eret_D(eret_D), .epc(epc), .jmp_D(jmp_D), .jmp_target(jmp_target),
    .br_taken_D(br_taken_D), .br_target(br_target), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc_F(pc_F), .redir_pend(redir_pend)
`ifdef FETCH_PERF_CNT_EN
    , .redir_cnt(redir_cnt), .wait_cnt(wait_cnt)
`endif
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task idle;
    stall_D = 0; req_exc = 0; eret_D = 0; jmp_D = 0; br_taken_D = 0;
    epc = 0; jmp_target = 0; br_target = 0;
  endtask
  task test_reset;
    idle(); imem_ready = 1; reset = 1;
    tick(); tick();
    checks++; if (pc_F !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_F, 32'h3000); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", redir_pend); end
    reset = 0;
    tick();
    checks++; if (pc_F !== 32'h3000 || imem_req !== 1'b1) begin errors++; $display("FAIL boot: pc %h req %b want 3000 1", pc_F, imem_req); end
    tick();
    checks++; if (pc_F !== 32'h3004) begin errors++; $display("FAIL seq1: got %h want %h", pc_F, 32'h3004); end
    tick();
    checks++; if (pc_F !== 32'h3008) begin errors++; $display("FAIL seq2: got %h want %h", pc_F, 32'h3008); end
  endtask
  task test_branch_pending;
    tick(); tick();
    checks++; if (pc_F !== 32'h3010) begin errors++; $display("FAIL seq3: got %h want %h", pc_F, 32'h3010); end
    imem_ready = 0; br_taken_D = 1; br_target = 32'h3100;
    tick();
    checks++; if (redir_pend !== 1'b1 || pc_F !== 32'h3010) begin errors++; $display("FAIL br_latch: pend %b pc %h want 1 3010", redir_pend, pc_F); end
    br_taken_D = 0;
    tick();
    checks++; if (redir_pend !== 1'b1 || pc_F !== 32'h3010) begin errors++; $display("FAIL br_hold: pend %b pc %h want 1 3010", redir_pend, pc_F); end
    imem_ready = 1;
    tick();
    checks++; if (redir_pend !== 1'b0 || pc_F !== 32'h3100) begin errors++; $display("FAIL br_load: pend %b pc %h want 0 3100", redir_pend, pc_F); end
    tick();
    checks++; if (pc_F !== 32'h3104) begin errors++; $display("FAIL br_next: got %h want %h", pc_F, 32'h3104); end
  endtask
  task test_stall;
    stall_D = 1;
    tick();
    checks++; if (pc_F !== 32'h3104) begin errors++; $display("FAIL stall_hold: got %h want %h", pc_F, 32'h3104); end
    br_taken_D = 1; br_target = 32'h3300;
    tick();
    checks++; if (pc_F !== 32'h3104 || redir_pend !== 1'b1) begin errors++; $display("FAIL stall_br: pc %h pend %b want 3104 1", pc_F, redir_pend); end
    idle();
    tick();
    checks++; if (pc_F !== 32'h3300 || redir_pend !== 1'b0) begin errors++; $display("FAIL stall_release: pc %h pend %b want 3300 0", pc_F, redir_pend); end
  endtask
  task test_exc_priority;
    req_exc = 1; jmp_D = 1; jmp_target = 32'h3200; stall_D = 1; imem_ready = 1;
    tick();
    checks++; if (pc_F !== 32'h4180) begin errors++; $display("FAIL exc_stall: got %h want %h", pc_F, 32'h4180); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL exc_pend: got %b want 0", redir_pend); end
    idle();
  endtask
  task test_overwrite;
    imem_ready = 0; jmp_D = 1; jmp_target = 32'h3200;
    tick();
    jmp_D = 0; eret_D = 1; epc = 32'h3050;
    tick();
    checks++; if (redir_pend !== 1'b1 || pc_F !== 32'h4180) begin errors++; $display("FAIL ow_wait: pend %b pc %h want 1 4180", redir_pend, pc_F); end
    eret_D = 0; imem_ready = 1;
    tick();
    checks++; if (pc_F !== 32'h3050) begin errors++; $display("FAIL ow_eret_wins: got %h want %h", pc_F, 32'h3050); end
    imem_ready = 0; eret_D = 1; epc = 32'h3050;
    tick();
    eret_D = 0; jmp_D = 1; jmp_target = 32'h3200;
    tick();
    jmp_D = 0; imem_ready = 1;
    tick();
    checks++; if (pc_F !== 32'h3050 || redir_pend !== 1'b0) begin errors++; $display("FAIL ow_eret_kept: pc %h pend %b want 3050 0", pc_F, redir_pend); end
  endtask
  task test_wrap;
    jmp_D = 1; jmp_target = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc_F !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jmp: got %h want %h", pc_F, 32'hFFFF_FFFC); end
    jmp_D = 0;
    tick();
    checks++; if (pc_F !== 32'h0) begin errors++; $display("FAIL wrap: got %h want %h", pc_F, 32'h0); end
    tick();
    checks++; if (pc_F !== 32'h4) begin errors++; $display("FAIL wrap_next: got %h want %h", pc_F, 32'h4); end
  endtask
  task test_reset_mid_wait;
    imem_ready = 0; br_taken_D = 1; br_target = 32'h3400;
    tick();
    br_taken_D = 0; req_exc = 1; reset = 1;
    tick();
    checks++; if (pc_F !== 32'h3000 || imem_req !== 1'b0 || redir_pend !== 1'b0) begin errors++; $display("FAIL reset_wait: pc %h req %b pend %b want 3000 0 0", pc_F, imem_req, redir_pend); end
    idle(); reset = 0; imem_ready = 1;
    tick(); tick();
    checks++; if (pc_F !== 32'h3004) begin errors++; $display("FAIL reset_wait_restart: got %h want %h", pc_F, 32'h3004); end
  endtask
`ifdef FETCH_PERF_CNT_EN
  task test_perf;
    reset = 1; idle(); imem_ready = 1;
    tick();
    reset = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      jmp_D = 1; jmp_target = 32'h5000 + 32'(i * 16);
      tick();
    end
    jmp_D = 0;
    checks++; if (redir_cnt !== 32'd3) begin errors++; $display("FAIL redir_cnt: got %0d want 3", redir_cnt); end
    imem_ready = 0;
    tick(); tick();
    imem_ready = 1;
    tick();
    checks++; if (wait_cnt !== 32'd2) begin errors++; $display("FAIL wait_cnt: got %0d want 2", wait_cnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_branch_pending();
    test_stall();
    test_exc_priority();
    test_overwrite();
    test_wrap();
    test_reset_mid_wait();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
